// File: rtl/nios2pio_onchip_mem_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single-port on-chip RAM.
// Round-robin with a bounded run of consecutive grants to one port, one
// access per cycle, and read data returned exactly one cycle after issue.
module nios2pio_onchip_mem_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int GRANT_LIMIT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   s0_address,
    input  logic [DATA_W/8-1:0] s0_byteenable,
    input  logic                s0_read,
    input  logic                s0_write,
    input  logic [DATA_W-1:0]   s0_writedata,
    output logic                s0_waitrequest,
    output logic [DATA_W-1:0]   s0_readdata,
    output logic                s0_readdatavalid,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic                s1_waitrequest,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam logic [3:0] LIMIT = 4'(GRANT_LIMIT);

    logic       last_grant_r;
    logic [3:0] run_cnt_r;
    logic       rd_pend_r;
    logic       rd_tag_r;

    logic       req0_s;
    logic       req1_s;
    logic       keep_s;
    logic       grant0_s;
    logic       grant1_s;
    logic       any_grant_s;
    logic       rd_issue_s;

    assign req0_s      = s0_read | s0_write;
    assign req1_s      = s1_read | s1_write;
    // A zero run count means nobody has been granted yet, so there is no run
    // to extend and the tie goes to the port that was not last granted.
    assign keep_s      = (run_cnt_r != 4'd0) && (run_cnt_r < LIMIT);
    assign any_grant_s = grant0_s | grant1_s;

    // Combinational grant: single requester wins, ties go round-robin with run limit.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!reset_n) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0_s && req1_s) begin
            if (keep_s) begin
                grant0_s = ~last_grant_r;
                grant1_s = last_grant_r;
            end else begin
                grant0_s = last_grant_r;
                grant1_s = ~last_grant_r;
            end
        end else if (req0_s) begin
            grant0_s = 1'b1;
        end else if (req1_s) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Mux the granted port onto the RAM; port 0 values when idle.
    always_comb begin
        mem_address    = s0_address;
        mem_byteenable = s0_byteenable;
        mem_writedata  = s0_writedata;
        if (grant1_s) begin
            mem_address    = s1_address;
            mem_byteenable = s1_byteenable;
            mem_writedata  = s1_writedata;
        end else begin
            mem_address    = s0_address;
            mem_byteenable = s0_byteenable;
            mem_writedata  = s0_writedata;
        end
    end

    assign mem_chipselect = any_grant_s;
    assign mem_write      = (grant0_s & s0_write) | (grant1_s & s1_write);
    assign mem_clken      = 1'b1;

    // A read with write also asserted is treated as a write: no return.
    assign rd_issue_s = (grant0_s & s0_read & ~s0_write) | (grant1_s & s1_read & ~s1_write);

    assign s0_waitrequest = req0_s & ~grant0_s;
    assign s1_waitrequest = req1_s & ~grant1_s;

    assign s0_readdata      = mem_readdata;
    assign s1_readdata      = mem_readdata;
    assign s0_readdatavalid = rd_pend_r & ~rd_tag_r;
    assign s1_readdatavalid = rd_pend_r & rd_tag_r;

    // Track grant history for arbitration and the one-deep read return pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= 1'b1;
            run_cnt_r    <= 4'd0;
            rd_pend_r    <= 1'b0;
            rd_tag_r     <= 1'b0;
        end else begin
            if (any_grant_s) begin
                if (grant1_s == last_grant_r) begin
                    if (run_cnt_r != 4'd15) begin
                        run_cnt_r <= run_cnt_r + 4'd1;
                    end else begin
                        run_cnt_r <= run_cnt_r;
                    end
                end else begin
                    run_cnt_r <= 4'd1;
                end
                last_grant_r <= grant1_s;
            end else begin
                run_cnt_r    <= run_cnt_r;
                last_grant_r <= last_grant_r;
            end
            rd_pend_r <= rd_issue_s;
            if (rd_issue_s) begin
                rd_tag_r <= grant1_s;
            end else begin
                rd_tag_r <= rd_tag_r;
            end
        end
    end

endmodule
